// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider, square-wave or single-pulse per channel.
// New ratios are staged and only take effect on a period boundary, so outputs never glitch.
module clkdiv_multi #(
   parameter  int NCH = 4,
   parameter  int DW  = 8,
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic           wr_en,
   input  logic [CW-1:0]  wr_ch,
   input  logic [DW-1:0]  wr_div,
   input  logic           wr_mode,
   output logic [NCH-1:0] clk_out,
   output logic [NCH-1:0] tick,
   output logic [NCH-1:0] busy
);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [DW-1:0] cnt_q, cnt_d;
      logic [DW-1:0] div_a_q, div_a_d;
      logic [DW-1:0] div_p_q, div_p_d;
      logic          mode_a_q, mode_a_d;
      logic          mode_p_q, mode_p_d;
      logic          pend_q, pend_d;
      logic          co_q, co_d;
      logic          tk_q, tk_d;
      logic          run, hit, last, bnd, run_n;
      logic [DW:0]   half;

      assign run   = (div_a_q >= DW'(2));
      assign hit   = wr_en && (wr_ch == CW'(i));
      assign last  = (cnt_q == div_a_q - DW'(1));
      assign bnd   = ena && (!run || last);
      assign run_n = (div_a_d >= DW'(2));
      // Extra bit keeps D+1 from wrapping at the maximum divisor.
      assign half  = ({1'b0, div_a_d} + (DW+1)'(1)) >> 1;

      always_comb begin
         cnt_d    = cnt_q;
         div_a_d  = div_a_q;
         div_p_d  = div_p_q;
         mode_a_d = mode_a_q;
         mode_p_d = mode_p_q;
         pend_d   = pend_q;
         co_d     = co_q;
         tk_d     = 1'b0;
         if (bnd && (hit || pend_q)) begin
            // A write landing on the boundary edge wins over the staged value.
            div_a_d  = hit ? wr_div  : div_p_q;
            mode_a_d = hit ? wr_mode : mode_p_q;
            cnt_d    = '0;
            pend_d   = 1'b0;
         end else begin
            if (hit) begin
               div_p_d  = wr_div;
               mode_p_d = wr_mode;
               pend_d   = 1'b1;
            end
            if (ena && run) begin
               cnt_d = last ? '0 : cnt_q + DW'(1);
            end
         end
         if (ena) begin
            tk_d = run_n && (cnt_d == '0);
            if (!run_n) begin
               co_d = 1'b0;
            end else if (mode_a_d) begin
               co_d = (cnt_d == '0);
            end else begin
               co_d = ({1'b0, cnt_d} < half);
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q    <= '0;
            div_a_q  <= '0;
            div_p_q  <= '0;
            mode_a_q <= 1'b0;
            mode_p_q <= 1'b0;
            pend_q   <= 1'b0;
            co_q     <= 1'b0;
            tk_q     <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            div_a_q  <= div_a_d;
            div_p_q  <= div_p_d;
            mode_a_q <= mode_a_d;
            mode_p_q <= mode_p_d;
            pend_q   <= pend_d;
            co_q     <= co_d;
            tk_q     <= tk_d;
         end
      end

      assign clk_out[i] = co_q;
      assign tick[i]    = tk_q;
      assign busy[i]    = pend_q;
   end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: stimulus queues per-cycle expectations,
// a monitor pops and compares them against the live outputs.
module tb_clkdiv_multi;

   logic       clk = 1'b0;
   logic       rst_n, ena, wr_en, wr_mode;
   logic [1:0] wr_ch;
   logic [7:0] wr_div;
   logic [3:0] clk_out, tick, busy;
   logic [2:0] clk_out2, tick2, busy2;

   clkdiv_multi #(.NCH(4), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
      .clk_out(clk_out), .tick(tick), .busy(busy)
   );

   clkdiv_multi #(.NCH(3), .DW(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .wr_en(wr_en),
      .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode),
      .clk_out(clk_out2), .tick(tick2), .busy(busy2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         d;
      int         ch;
      logic [2:0] exp;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic push(int t, int d, int ch, logic [2:0] e, string nm);
      exp_t x;
      x.cyc = t; x.d = d; x.ch = ch; x.exp = e; x.nm = nm;
      sb.push_back(x);
   endtask

   // Expected clk_out/tick/busy patterns, one character per cycle, repeating.
   task automatic run(int t0, int d, int ch, string co, string tk,
                      string bz, int n, string nm);
      logic [2:0] e;
      for (int k = 0; k < n; k++) begin
         e[2] = (co[k % co.len()] == 8'h31);
         e[1] = (tk[k % tk.len()] == 8'h31);
         e[0] = (bz[k % bz.len()] == 8'h31);
         push(t0 + k, d, ch, e, nm);
      end
   endtask

   task automatic chk(string nm, logic [11:0] act, logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b", nm, act, exp);
      end
   endtask

   initial begin : monitor
      logic [2:0] act;
      forever begin
         @(posedge clk);
         #2;
         for (int j = 0; j < sb.size();) begin
            if (sb[j].cyc <= cyc) begin
               if (sb[j].d == 0)
                  act = {clk_out[sb[j].ch], tick[sb[j].ch], busy[sb[j].ch]};
               else
                  act = {clk_out2[sb[j].ch], tick2[sb[j].ch], busy2[sb[j].ch]};
               checks++;
               if (sb[j].cyc < cyc || act !== sb[j].exp) begin
                  errors++;
                  $display("FAIL %s dut%0d ch%0d cyc%0d: got co/tk/bz=%b required %b",
                           sb[j].nm, sb[j].d, sb[j].ch, sb[j].cyc, act, sb[j].exp);
               end
               sb.delete(j);
            end else begin
               j++;
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wr(int ch, int d, bit m);
      wr_ch   = 2'(ch);
      wr_div  = 8'(d);
      wr_mode = m;
      wr_en   = 1'b1;
      next();
   endtask

   task automatic wait_until(int t);
      while (cyc < t) next();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         next();
         n++;
      end
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic do_reset();
      drain();
      rst_n = 1'b0;
      ena   = 1'b1;
      next();
      rst_n = 1'b1;
      next();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int c;
      rst_n = 1'b1; ena = 1'b1; wr_en = 1'b0;
      wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      chk("reset_state", {clk_out, tick, busy}, 12'h000);
      chk("reset_state3", {3'b0, clk_out2, tick2, busy2}, 12'h000);
      next();
      rst_n = 1'b1;
      next();

      // Async reset in the middle of a running channel
      c = cyc;
      run(c + 1, 0, 0, "1100", "1000", "0", 6, "pre_rst");
      wr(0, 4, 0);
      wait_until(c + 6);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {clk_out, tick, busy}, 12'h000);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      c = cyc;
      run(c + 1, 0, 0, "0", "0", "0", 5, "post_rst");

      // Square even/odd, D=2, and pulse mode
      do_reset();
      c = cyc;
      run(c + 1, 0, 0, "1100", "1000", "0", 12, "sq4");
      run(c + 2, 0, 1, "11100", "10000", "0", 12, "sq5");
      run(c + 3, 0, 2, "10", "10", "0", 12, "sq2");
      run(c + 4, 0, 3, "100", "100", "0", 12, "pulse3");
      wr(0, 4, 0);
      wr(1, 5, 0);
      wr(2, 2, 0);
      wr(3, 3, 1);

      // Ratio change mid-period, then stop
      do_reset();
      c = cyc;
      run(c + 1, 0, 0, "111000", "100000", "000111", 6, "d6_to_d3");
      run(c + 7, 0, 0, "110", "100", "000", 4, "d3");
      run(c + 11, 0, 0, "100000", "000000", "110000", 6, "stop");
      wr(0, 6, 0);
      wait_until(c + 3);
      wr(0, 3, 0);
      wait_until(c + 10);
      wr(0, 0, 0);

      // Overwrite of pending value, then write on the apply edge
      do_reset();
      c = cyc;
      run(c + 1, 0, 0, "11001111100000", "10001000000000",
          "01110000000000", 14, "overwrite");
      run(c + 15, 0, 0, "10", "10", "00", 6, "collide");
      wr(0, 4, 0);
      wr(0, 8, 0);
      wr(0, 10, 0);
      wait_until(c + 14);
      wr(0, 2, 0);

      // ena freeze for 7 cycles, write lands in pending meanwhile
      do_reset();
      c = cyc;
      run(c + 1, 0, 0, "1111111110011", "1000000000010", "0", 13, "freeze0");
      run(c + 1, 0, 1, "000000000101", "000000000101",
          "000011111000", 12, "freeze1");
      wr(0, 4, 0);
      next();
      ena = 1'b0;
      wait_until(c + 4);
      wr(1, 2, 0);
      wait_until(c + 9);
      ena = 1'b1;
      next();

      // Out-of-range channel on a 3-channel instance
      do_reset();
      c = cyc;
      for (int ch = 0; ch < 3; ch++)
         run(c + 1, 1, ch, "0", "0", "0", 5, "bad_ch");
      run(c + 6, 1, 2, "10", "10", "00", 4, "ch2_pulse");
      run(c + 6, 1, 0, "0", "0", "0", 2, "ch0_idle");
      wr(3, 4, 0);
      wait_until(c + 5);
      wr(2, 2, 1);

      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Parametrised multi-channel programmable clock divider, the successor to the single fixed divider in the TT user project. Each of NCH channels divides the system clock by a run-time programmable ratio, in square-wave or single-pulse mode. Ratio and mode changes are glitch-free because they take effect only at a period boundary. Sits behind the tt_um top, with config writes driven from ui_in/uio_in decode and outputs routed to uo_out.

Parameters:
NCH, 4, number of independent divider channels (1..8)
DW, 8, divisor and counter width in bits
CW, $clog2(NCH) (min 1), channel-select width (derived, not overridden)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all channels
wr_en  in  1  config write strobe, one write per cycle
wr_ch  in  CW  target channel; values >= NCH ignored
wr_div  in  DW  divisor D; 0 or 1 = channel stopped
wr_mode  in  1  0 = square wave, 1 = pulse
clk_out  out  NCH  divided clock per channel, registered
tick  out  NCH  1-cycle strobe at start of each period, registered
busy  out  NCH  pending config not yet applied

Behaviour:
- Reset (async, rst_n low): all cnt=0, div_a=0 (stopped), mode_a=0, pending cleared; clk_out=0, tick=0, busy=0. Release is synchronous to the next clk edge.
- Per-channel state:
  - active div_a, mode_a
  - pending div_p, mode_p, pend flag
  - counter cnt[DW-1:0]
- Running channel (div_a>=2, ena=1):
  - cnt <= (cnt==div_a-1) ? 0 : cnt+1.
  - Period = div_a cycles exactly.
- Outputs are flops loaded from next-state cnt, so clk_out and tick are glitch-free.
  - Square mode: clk_out=1 while cnt < H, H=(div_a+1)>>1, computed in DW+1 bits with no overflow at D=2^DW-1. Example: D=5 gives 3 high, 2 low.
  - Pulse mode: clk_out=1 only when cnt==0.
  - tick=1 when cnt==0 on a running channel, in either mode.
- Stopped channel (div_a<2): cnt=0, clk_out=0, tick=0.
- Write (wr_en=1, wr_ch=i<NCH): captured into div_p/mode_p, pend=1. A write to a pending channel overwrites it (last write wins).
- Apply point: edge where ena=1 and either (running and cnt==div_a-1) or (stopped).
  - At apply: div_a<=div_p, mode_a<=mode_p, cnt<=0, pend<=0.
  - A write to the same channel on the apply edge bypasses pending and is applied directly; busy stays 0.
- Latency: write on a stopped channel sampled at edge k gives tick=1 and clk_out=1 from edge k (visible in the cycle after the write cycle).
- No truncated or stretched period is ever produced: the old period always completes in full.
- busy[i] = pend[i]. It asserts the cycle after an unapplied write and clears on the apply edge.
- ena=0:
  - cnt, clk_out, mode_a and div_a hold.
  - tick forced to 0.
  - Writes still land in pending; no apply occurs.
- ena rising: counting resumes from the held cnt, with no extra tick.
- Writing D=0/1 to a running channel stops it at the next boundary. clk_out=0 from the apply edge.
- Channels are fully independent. Simultaneous boundaries on several channels are all applied on the same edge.

Test Plan:
- Reset mid-operation: ch0 running D=4, assert rst_n low asynchronously between edges -> clk_out, tick, busy = 0 immediately; after release, ch0 stays stopped until written.
- Square even/odd: ch0 D=4 mode 0 -> clk_out 1100 repeating, tick every 4 cycles. ch1 D=5 -> 11100 repeating. ch2 D=2 -> 10 repeating, tick every 2 cycles.
- Pulse mode: ch3 D=3 mode 1 -> clk_out = tick = 100 repeating. First tick in the cycle after the write.
- Ratio change mid-period, then stop:
  - ch0 D=6 running; at cnt=2 write D=3 -> busy=1 for 3 cycles, period of 6 completes fully, then 111000 is followed by 110 repeating.
  - ch0 running D=3; write D=0 -> stops at boundary, clk_out=0, busy clears.
- Overwrite and boundary collision:
  - Write D=8 then D=10 before boundary -> D=10 applied.
  - Write coinciding with the apply edge -> applied, busy never asserts.
- ena freeze plus invalid channel:
  - ena=0 for 7 cycles at cnt=1 -> outputs frozen, no ticks; resume from cnt=1.
  - With NCH=3, CW=2: wr_ch=3 -> no state change on any channel.
